// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the systolic west-edge feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // Number of skewed feed steps needed to push a W x L operand into the array.
  function automatic int nstep(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Width of a counter able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : (($clog2(n + 1) < 1) ? 1 : $clog2(n + 1));
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Handshake and operand/result bus between controller, ROM side and PE array.
// SYSTOLIC_FEED_PERF_EN adds the perf_cycles/perf_stalls observation counters.
interface systolic_feed_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2
);
  logic                                            start;
  logic                                            hold;
  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] data_rom;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              out_data;
  logic [0:ARRAY_W-1]                              out_valid;
  logic                                            busy;
  logic                                            done;
`ifdef SYSTOLIC_FEED_PERF_EN
  logic [31:0]                                     perf_cycles;
  logic [15:0]                                     perf_stalls;

  modport master (
    output start, hold, data_rom,
    input  out_data, out_valid, busy, done, perf_cycles, perf_stalls
  );
  modport slave (
    input  start, hold, data_rom,
    output out_data, out_valid, busy, done, perf_cycles, perf_stalls
  );
`else
  modport master (
    output start, hold, data_rom,
    input  out_data, out_valid, busy, done
  );
  modport slave (
    input  start, hold, data_rom,
    output out_data, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/systolic_feed_ctrl_skew_row.sv
// One west-edge row: emits row ROW's elements on steps ROW..ROW+ARRAY_L-1,
// giving the diagonal skew without a per-row delay line.
module systolic_skew_row
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_L    = 2,
  parameter int ROW        = 0,
  parameter int STEP_W     = 3
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                active,
  input  logic                                hold,
  input  logic [STEP_W-1:0]                   step,
  input  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]  row_data,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] elem;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  vld_p1;

  always_comb begin
    hit  = 1'b0;
    elem = '0;
    for (int j = 0; j < ARRAY_L; j++) begin
      if (step == STEP_W'(ROW + j)) begin
        hit  = 1'b1;
        elem = row_data[j];
      end
    end
  end

  // Stage p1: registered element into the array. A held step keeps the
  // previous element on the wire but drops valid, so it is re-issued later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (!active) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (hold) begin
      vld_p1  <= 1'b0;
    end else begin
      data_p1 <= hit ? elem : '0;
      vld_p1  <= hit;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feeds a captured ARRAY_W x ARRAY_L operand into the systolic array west edge
// with diagonal skew, then drains and pulses done. Option: SYSTOLIC_FEED_PERF_EN.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_W      = 5,
  parameter int ARRAY_L      = 2,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  systolic_feed_ctrl_if.slave bus
);

  localparam int NSTEP = nstep(ARRAY_W, ARRAY_L);
  localparam int SW    = cnt_w(NSTEP);
  localparam int DCW   = cnt_w(DRAIN_CYCLES);
  localparam logic [SW-1:0]  LAST_STEP  = SW'(NSTEP - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  feed_state_t state, state_d;
  logic [SW-1:0]  step, step_d;
  logic [DCW-1:0] drain, drain_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           cap;
  logic           feeding;

  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] mat;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]              row_data;
  logic [0:ARRAY_W-1]                              row_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      step   <= '0;
      drain  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      step   <= step_d;
      drain  <= drain_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // DONE lasts two edges: the first raises done, the second returns to IDLE,
  // so start cannot be accepted while done is still visible.
  always_comb begin
    state_d = state;
    step_d  = step;
    drain_d = drain;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          cap     = 1'b1;
          step_d  = '0;
          drain_d = '0;
          busy_d  = 1'b1;
          state_d = FEED;
        end
      end
      FEED: begin
        if (!bus.hold) begin
          if (step == LAST_STEP) begin
            step_d  = '0;
            drain_d = '0;
            state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          end else begin
            step_d = step + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!bus.hold) begin
          if (drain == LAST_DRAIN) begin
            drain_d = '0;
            state_d = DONE;
          end else begin
            drain_d = drain + 1'b1;
          end
        end
      end
      DONE: begin
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: operand snapshot, so ROM changes mid-run cannot leak in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat <= '0;
    end else if (cap) begin
      mat <= bus.data_rom;
    end
  end

  assign feeding = (state == FEED);

  for (genvar i = 0; i < ARRAY_W; i++) begin : g_row
    systolic_skew_row #(
      .DATA_WIDTH (DATA_WIDTH),
      .ARRAY_L    (ARRAY_L),
      .ROW        (i),
      .STEP_W     (SW)
    ) u_row (
      .clk       (clk),
      .reset_n   (reset_n),
      .active    (feeding),
      .hold      (bus.hold),
      .step      (step),
      .row_data  (mat[i]),
      .out_data  (row_data[i]),
      .out_valid (row_vld[i])
    );
  end

  assign bus.out_data  = row_data;
  assign bus.out_valid = row_vld;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SYSTOLIC_FEED_PERF_EN
  logic [31:0] perf_cyc_q;
  logic [15:0] perf_stl_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  // Counts the edges of a run from the first feed edge to the done edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else if (cap) begin
      perf_cyc_q <= '0;
      perf_stl_q <= '0;
    end else if (state == FEED || state == DRAIN) begin
      perf_cyc_q <= sat_inc32(perf_cyc_q);
      if (bus.hold) begin
        perf_stl_q <= sat_inc16(perf_stl_q);
      end
    end else if (state == DONE && !done_q) begin
      perf_cyc_q <= sat_inc32(perf_cyc_q);
    end
  end

  assign bus.perf_cycles = perf_cyc_q;
  assign bus.perf_stalls = perf_stl_q;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: default 5x2 instance plus a 1x1 no-drain instance.
module tb_systolic_feed_ctrl;

  logic clk;
  logic reset_n;
  int   ecnt;
  int   n_tests;
  int   n_fail;
  bit   end_req;
  bit   mon_done;

  systolic_feed_ctrl_if #(.DATA_WIDTH(8), .ARRAY_W(5), .ARRAY_L(2)) a_if ();
  systolic_feed_ctrl_if #(.DATA_WIDTH(8), .ARRAY_W(1), .ARRAY_L(1)) b_if ();

  systolic_feed_ctrl #(.DATA_WIDTH(8), .ARRAY_W(5), .ARRAY_L(2), .DRAIN_CYCLES(5)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave));
  systolic_feed_ctrl #(.DATA_WIDTH(8), .ARRAY_W(1), .ARRAY_L(1), .DRAIN_CYCLES(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave));

  typedef struct {
    int              edge_n;
    bit              dut_b;
    logic [0:4]      vld;
    logic [0:4][7:0] data;
    logic            busy;
    logic            done;
    bit              chk_perf;
    logic [31:0]     pc;
    logic [15:0]     ps;
    int              tag;
  } exp_t;

  exp_t sb[$];

  logic [0:4]      svld [0:5];
  logic [0:4][7:0] sdat [0:5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int edge_n, input bit dut_b, input logic [0:4] vld,
                           input logic [0:4][7:0] data, input logic busy, input logic done,
                           input bit chk_perf, input logic [31:0] pc, input logic [15:0] ps,
                           input int tag);
    exp_t e;
    e.edge_n = edge_n; e.dut_b = dut_b; e.vld = vld; e.data = data;
    e.busy = busy; e.done = done; e.chk_perf = chk_perf; e.pc = pc; e.ps = ps; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic load_a(input int base, input int mult);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 2; j++)
        a_if.data_rom[i][j] = 8'(base + mult * i + j);
  endtask

  // Plain run, optionally with a second (ignored) start at E4 carrying other data.
  task automatic run_plain(input int tag, input bit second_start);
    int e0;
    load_a(0, 10);
    a_if.start = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0, 0, 5'b0, '0, 1'b1, 1'b0, 1, 32'd0, 16'd0, tag);
    for (int s = 0; s < 6; s++)
      expect_at(e0 + 1 + s, 0, svld[s], sdat[s], 1'b1, 1'b0, s == 0, 32'd1, 16'd0, tag + 1 + s);
    expect_at(e0 + 12, 0, 5'b0, '0, 1'b1, 1'b1, 1, 32'd12, 16'd0, tag + 7);
    expect_at(e0 + 13, 0, 5'b0, '0, 1'b0, 1'b0, 1, 32'd12, 16'd0, tag + 8);
    tick();
    a_if.start = 1'b0;
    if (second_start) begin
      repeat (3) tick();
      load_a(200, 3);
      a_if.start = 1'b1;
      tick();
      a_if.start = 1'b0;
      repeat (10) tick();
    end else begin
      repeat (14) tick();
    end
  endtask

  // Hold sampled on E3, E4, E5.
  task automatic run_hold(input int tag);
    int e0;
    load_a(0, 10);
    a_if.start = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0, 0, 5'b0, '0, 1'b1, 1'b0, 1, 32'd0, 16'd0, tag);
    expect_at(e0 + 1, 0, svld[0], sdat[0], 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + 1);
    expect_at(e0 + 2, 0, svld[1], sdat[1], 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + 2);
    for (int k = 3; k < 6; k++)
      expect_at(e0 + k, 0, 5'b0, sdat[1], 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + k);
    for (int s = 2; s < 6; s++)
      expect_at(e0 + 4 + s, 0, svld[s], sdat[s], 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + 4 + s);
    expect_at(e0 + 15, 0, 5'b0, '0, 1'b1, 1'b1, 1, 32'd15, 16'd3, tag + 10);
    expect_at(e0 + 16, 0, 5'b0, '0, 1'b0, 1'b0, 1, 32'd15, 16'd3, tag + 11);
    tick();
    a_if.start = 1'b0;
    repeat (2) tick();
    a_if.hold = 1'b1;
    repeat (3) tick();
    a_if.hold = 1'b0;
    repeat (11) tick();
  endtask

  // Asynchronous reset right after E5, mid-feed.
  task automatic run_reset(input int tag);
    int e0;
    load_a(0, 10);
    a_if.start = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0, 0, 5'b0, '0, 1'b1, 1'b0, 0, 32'd0, 16'd0, tag);
    for (int s = 0; s < 4; s++)
      expect_at(e0 + 1 + s, 0, svld[s], sdat[s], 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + 1 + s);
    expect_at(e0 + 5, 0, 5'b0, '0, 1'b0, 1'b0, 1, 32'd0, 16'd0, tag + 5);
    tick();
    a_if.start = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (16) tick();
  endtask

  task automatic run_b(input int tag);
    int e0;
    b_if.data_rom[0][0] = 8'hFF;
    b_if.start = 1'b1;
    e0 = ecnt + 1;
    expect_at(e0,     1, 5'b0,     '0,            1'b1, 1'b0, 1, 32'd0, 16'd0, tag);
    expect_at(e0 + 1, 1, 5'b10000, {8'hFF, 32'h0}, 1'b1, 1'b0, 0, 32'd0, 16'd0, tag + 1);
    expect_at(e0 + 2, 1, 5'b0,     '0,            1'b1, 1'b1, 1, 32'd2, 16'd0, tag + 2);
    expect_at(e0 + 3, 1, 5'b0,     '0,            1'b0, 1'b0, 1, 32'd2, 16'd0, tag + 3);
    tick();
    b_if.start = 1'b0;
    repeat (5) tick();
  endtask

  // Monitor: pops whatever is due at this edge and flags unexpected activity.
  initial begin
    exp_t            e;
    bit              seen_a, seen_b, ok;
    logic [0:4]      act_vld;
    logic [0:4][7:0] act_dat;
    logic            act_busy, act_done;
    logic [31:0]     act_pc;
    logic [15:0]     act_ps;
    forever begin
      @(negedge clk);
      seen_a = 1'b0;
      seen_b = 1'b0;
      while (sb.size() > 0 && sb[0].edge_n <= ecnt) begin
        e = sb.pop_front();
        n_tests++;
        if (e.edge_n < ecnt) begin
          n_fail++;
          $display("FAIL chk%0d missed: observed at edge %0d, required at edge %0d", e.tag, ecnt, e.edge_n);
          continue;
        end
        act_pc = '0;
        act_ps = '0;
        if (e.dut_b) begin
          seen_b   = 1'b1;
          act_vld  = {b_if.out_valid[0], 4'b0};
          act_dat  = {b_if.out_data[0], 32'h0};
          act_busy = b_if.busy;
          act_done = b_if.done;
`ifdef SYSTOLIC_FEED_PERF_EN
          act_pc = b_if.perf_cycles;
          act_ps = b_if.perf_stalls;
`endif
        end else begin
          seen_a   = 1'b1;
          act_vld  = a_if.out_valid;
          act_dat  = a_if.out_data;
          act_busy = a_if.busy;
          act_done = a_if.done;
`ifdef SYSTOLIC_FEED_PERF_EN
          act_pc = a_if.perf_cycles;
          act_ps = a_if.perf_stalls;
`endif
        end
        ok = (act_vld === e.vld) && (act_dat === e.data) &&
             (act_busy === e.busy) && (act_done === e.done);
`ifdef SYSTOLIC_FEED_PERF_EN
        if (e.chk_perf && ((act_pc !== e.pc) || (act_ps !== e.ps))) begin
          ok = 1'b0;
          $display("FAIL perf%0d edge %0d: cycles=%0d stalls=%0d, required cycles=%0d stalls=%0d",
                   e.tag, ecnt, act_pc, act_ps, e.pc, e.ps);
        end
`endif
        if (!ok) begin
          n_fail++;
          $display("FAIL chk%0d edge %0d dut_%s: vld=%b data=%h busy=%b done=%b, required vld=%b data=%h busy=%b done=%b",
                   e.tag, ecnt, e.dut_b ? "b" : "a", act_vld, act_dat, act_busy, act_done,
                   e.vld, e.data, e.busy, e.done);
        end
      end
      if (!seen_a && (a_if.out_valid !== 5'b0 || a_if.done !== 1'b0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_a edge %0d: vld=%b done=%b, required vld=00000 done=0",
                 ecnt, a_if.out_valid, a_if.done);
      end
      if (!seen_b && (b_if.out_valid !== 1'b0 || b_if.done !== 1'b0)) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_b edge %0d: vld=%b done=%b, required vld=0 done=0",
                 ecnt, b_if.out_valid, b_if.done);
      end
      if (end_req && !mon_done) begin
        n_tests++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    ecnt = 0; n_tests = 0; n_fail = 0; end_req = 1'b0; mon_done = 1'b0;
    svld[0] = 5'b10000; sdat[0] = {8'd0,  8'd0,  8'd0,  8'd0,  8'd0};
    svld[1] = 5'b11000; sdat[1] = {8'd1,  8'd10, 8'd0,  8'd0,  8'd0};
    svld[2] = 5'b01100; sdat[2] = {8'd0,  8'd11, 8'd20, 8'd0,  8'd0};
    svld[3] = 5'b00110; sdat[3] = {8'd0,  8'd0,  8'd21, 8'd30, 8'd0};
    svld[4] = 5'b00011; sdat[4] = {8'd0,  8'd0,  8'd0,  8'd31, 8'd40};
    svld[5] = 5'b00001; sdat[5] = {8'd0,  8'd0,  8'd0,  8'd0,  8'd41};
    a_if.start = 1'b0; a_if.hold = 1'b0; a_if.data_rom = '0;
    b_if.start = 1'b0; b_if.hold = 1'b0; b_if.data_rom = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    expect_at(ecnt + 1, 0, 5'b0, '0, 1'b0, 1'b0, 1, 32'd0, 16'd0, 0);
    expect_at(ecnt + 1, 1, 5'b0, '0, 1'b0, 1'b0, 1, 32'd0, 16'd0, 1);
    repeat (2) tick();
    run_plain(100, 0);
    run_hold(200);
    run_plain(300, 1);
    run_reset(400);
    run_plain(500, 0);
    run_b(600);
    end_req = 1'b1;
    for (int k = 0; k < 5 && !mon_done; k++) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
